// File: rtl/bus_demux4.sv
// One-initiator, four-target bus steering unit: decodes the target from the top
// address bits and forwards one request. It returns a single response beat on ack or timeout.
module bus_demux4 #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m_req,
  input  logic            m_we,
  input  logic [AW-1:0]   m_addr,
  input  logic [DW-1:0]   m_wdata,
  output logic            m_ready,
  output logic            m_ack,
  output logic [DW-1:0]   m_rdata,
  output logic            m_err,
  output logic [3:0]      s_req,
  output logic            s_we,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_wdata,
  input  logic [3:0]      s_ack,
  input  logic [4*DW-1:0] s_rdata,
  output logic [1:0]      dbg_state
);

  // Handshake: a request is taken on a rising edge where m_req=1 and m_ready=1.
  // Exactly one m_ack pulse follows each accepted request unless reset intervenes.

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [1:0]    sel;
  logic [CW-1:0] cnt;
  logic          sel_ack;
  logic [DW-1:0] sel_rdata;

  assign dbg_state = state;

  // Only the addressed target's ack and data are ever looked at.
  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    case (sel)
      2'd0: begin sel_ack = s_ack[0]; sel_rdata = s_rdata[0*DW +: DW]; end
      2'd1: begin sel_ack = s_ack[1]; sel_rdata = s_rdata[1*DW +: DW]; end
      2'd2: begin sel_ack = s_ack[2]; sel_rdata = s_rdata[2*DW +: DW]; end
      default: begin sel_ack = s_ack[3]; sel_rdata = s_rdata[3*DW +: DW]; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= 2'd0;
      cnt     <= '0;
      m_ready <= 1'b1;
      m_ack   <= 1'b0;
      m_rdata <= '0;
      m_err   <= 1'b0;
      s_req   <= 4'b0000;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          m_ack <= 1'b0;
          if (m_req) begin
            s_we    <= m_we;
            s_addr  <= m_addr;
            s_wdata <= m_wdata;
            sel     <= m_addr[AW-1:AW-2];
            s_req   <= 4'b0001 << m_addr[AW-1:AW-2];
            cnt     <= '0;
            m_ready <= 1'b0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          // An ack on the final counted cycle still wins over the timeout.
          if (sel_ack) begin
            m_rdata <= s_we ? '0 : sel_rdata;
            m_err   <= 1'b0;
            m_ack   <= 1'b1;
            s_req   <= 4'b0000;
            state   <= RESP;
          end else if (cnt == CNT_LAST) begin
            m_rdata <= '0;
            m_err   <= 1'b1;
            m_ack   <= 1'b1;
            s_req   <= 4'b0000;
            state   <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          m_ack   <= 1'b0;
          m_ready <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          m_ack   <= 1'b0;
          m_ready <= 1'b1;
          s_req   <= 4'b0000;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_demux4.sv
// Bench for bus_demux4: directed test-plan cases plus randomized transactions,
// each checked cycle by cycle against expectations derived from the transaction rules.
module tb_bus_demux4;
  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int TIMEOUT = 16;

  logic            clk;
  logic            rst_n;
  logic            m_req;
  logic            m_we;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic            m_ready;
  logic            m_ack;
  logic [DW-1:0]   m_rdata;
  logic            m_err;
  logic [3:0]      s_req;
  logic            s_we;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [3:0]      s_ack;
  logic [4*DW-1:0] s_rdata;
  logic [1:0]      dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [DW:0] exp_q[$];

  bus_demux4 #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver + checker for one transaction. Called at a negedge with the unit idle.
  // ack_cycle: BUSY-relative cycle at which the target acks (0 or >TIMEOUT = never in time).
  task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] rd_val, input int ack_cycle,
                         input bit hold, input bit stray);
    logic [1:0]    sel;
    logic [3:0]    onehot;
    logic [3:0]    a;
    bit            ack_ok;
    int            resp;
    logic [DW-1:0] exp_rd;
    logic [DW:0]   exp_resp;
    sel    = addr[AW-1:AW-2];
    onehot = 4'b0001 << sel;
    ack_ok = (ack_cycle >= 1) && (ack_cycle <= TIMEOUT);
    resp   = ack_ok ? ack_cycle + 1 : TIMEOUT + 1;
    exp_rd = (ack_ok && !we) ? rd_val : '0;
    exp_q.push_back({!ack_ok, exp_rd});
    exp_resp = '0;

    chk("ready_before_req", m_ready, 1);
    for (int i = 0; i < 4; i++) s_rdata[i*DW +: DW] = $urandom();
    s_rdata[int'(sel)*DW +: DW] = rd_val;
    s_ack   = 4'b0000;
    m_req   = 1'b1;
    m_we    = we;
    m_addr  = addr;
    m_wdata = wdata;

    for (int c = 1; c <= resp + 1; c++) begin
      @(negedge clk);
      if (hold && c <= resp) begin
        m_req   = 1'b1;
        m_we    = 1'($urandom());
        m_addr  = $urandom();
        m_wdata = $urandom();
      end else begin
        m_req = 1'b0;
      end
      if (c == 1) begin
        chk("s_we", s_we, we);
        chk("s_addr", s_addr, addr);
        chk("s_wdata", s_wdata, wdata);
      end
      chk("s_req", s_req, (c < resp) ? onehot : 4'b0000);
      chk("m_ack", m_ack, (c == resp));
      chk("m_ready", m_ready, (c == resp + 1));
      if (c == resp) begin
        if (exp_q.size() > 0) exp_resp = exp_q.pop_front();
        chk("resp_err_rdata", {m_err, m_rdata}, exp_resp);
      end
      if (c == resp + 1) chk("resp_hold", {m_err, m_rdata}, exp_resp);
      a = stray ? 4'($urandom()) : 4'b0000;
      if (c < resp) a = a & ~onehot;
      if (c == ack_cycle) a = a | onehot;
      s_ack = a;
    end
    m_req = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    m_req   = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    s_ack   = 4'b0000;
    s_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", m_ready, 1);
    chk("rst_ack", m_ack, 0);
    chk("rst_outputs", {m_err, m_rdata, s_req, s_we}, '0);
    chk("rst_buses", {s_addr, s_wdata}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed test-plan cases
    run_txn(1'b1, 32'h4000_0010, 32'h1234_5678, 32'hDEAD_BEEF, 4, 1'b0, 1'b0);
    run_txn(1'b0, 32'h8000_0004, 32'h0000_0000, 32'hCAFE_F00D, 1, 1'b0, 1'b0);
    run_txn(1'b0, 32'hC000_0100, 32'h0000_0000, 32'h1111_2222, 0, 1'b0, 1'b0);
    run_txn(1'b0, 32'h0000_0040, 32'h0000_0000, 32'h5A5A_A5A5, 6, 1'b0, 1'b1);
    run_txn(1'b0, 32'h4000_0008, 32'h0000_0000, 32'h0BAD_CAFE, TIMEOUT, 1'b0, 1'b0);
    run_txn(1'b1, 32'hC000_0000, 32'hFFFF_0000, 32'h7777_7777, TIMEOUT + 1, 1'b0, 1'b0);
    // Back-to-back with m_req held high throughout
    run_txn(1'b0, 32'h8000_0020, 32'h0, 32'h0102_0304, 2, 1'b1, 1'b0);
    run_txn(1'b1, 32'h0000_0030, 32'hAABB_CCDD, 32'h0, 1, 1'b1, 1'b0);

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom()), $urandom(), $urandom(), $urandom(),
              $urandom_range(0, TIMEOUT + 3), 1'($urandom()), 1'($urandom()));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Reset mid-BUSY: outputs clear asynchronously and no response follows
    m_req   = 1'b1;
    m_we    = 1'b0;
    m_addr  = 32'hC000_0044;
    m_wdata = 32'h1357_9BDF;
    @(negedge clk);
    m_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_before_reset", s_req, 4'b1000);
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", s_req, 4'b0000);
    chk("async_rst_ready", m_ready, 1);
    chk("async_rst_resp", {m_ack, m_err, m_rdata}, '0);
    chk("async_rst_buses", {s_we, s_addr, s_wdata}, '0);
    s_ack = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("in_reset_ack", m_ack, 0);
    end
    rst_n = 1'b1;
    s_ack = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_ack", m_ack, 0);
      chk("post_reset_ready", m_ready, 1);
    end
    run_txn(1'b0, 32'h4000_0000, 32'h0, 32'h600D_600D, 3, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
